offset_loader: RTL and testbench

//  Serial-to-parallel producer for the offset vector consumed by the offsets adder.
//  - Accepts one data_type offset per handshake into a shadow bank.
//  - Commits a complete set of OUT_SIZE offsets to the active bank on apply_i.
//  - Active bank drives offset_o, so offsets change only at controller-chosen

---
 rtl/offset_loader_pkg.sv | 11 +
 rtl/offset_loader.sv | 90 +++++++++
 tb/tb_offset_loader.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/offset_loader_pkg.sv
// Shared types and sizes for the offset loader and the offsets adder.
package offset_loader_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned OFFSET_SIZE = 16;

  typedef logic signed [DATA_W-1:0] data_type;

  typedef enum logic {LD_FILL, LD_FULL} loader_state_t;

endpackage

// File: rtl/offset_loader.sv
// Double-buffered offset loader: serial fill of a shadow bank, atomic commit to the active bank.
module offset_loader
  import offset_loader_pkg::*;
#(
  parameter int unsigned OUT_SIZE = OFFSET_SIZE
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          wr_valid_i,
  input  data_type                      wr_data_i,
  output logic                          wr_ready_o,
  input  logic                          abort_i,
  input  logic                          apply_i,
  output data_type [0:OUT_SIZE-1]       offset_o,
  output logic                          offset_valid_o,
  output logic [$clog2(OUT_SIZE+1)-1:0] fill_cnt_o,
  output logic                          full_o
);

  localparam int unsigned CNT_W = $clog2(OUT_SIZE+1);

  loader_state_t             state_q, state_d;
  data_type [0:OUT_SIZE-1]   shadow_q;
  data_type [0:OUT_SIZE-1]   active_q;
  logic [CNT_W-1:0]          fill_cnt_q;
  logic                      rdy_q;
  logic                      valid_q;
  logic                      accept_c;
  logic                      commit_c;

  // Handshake and commit qualifiers derived from the current state
  always_comb begin
    wr_ready_o = rdy_q & (state_q == LD_FILL) & ~abort_i;
    accept_c   = wr_valid_i & wr_ready_o;
    commit_c   = (state_q == LD_FULL) & apply_i;
  end

  // Next-state logic; apply beats abort in FULL, abort beats a word in FILL
  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_FILL: begin
        if (!abort_i && accept_c && (fill_cnt_q == CNT_W'(OUT_SIZE - 1)))
          state_d = LD_FULL;
      end
      LD_FULL: begin
        if (apply_i || abort_i)
          state_d = LD_FILL;
      end
      default: state_d = LD_FILL;
    endcase
  end

  // Shadow bank, active bank, fill counter and state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= LD_FILL;
      shadow_q   <= '0;
      active_q   <= '0;
      fill_cnt_q <= '0;
      rdy_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      rdy_q   <= 1'b1;
      state_q <= state_d;
      if (commit_c) begin
        active_q   <= shadow_q;
        valid_q    <= 1'b1;
        fill_cnt_q <= '0;
      end else if (abort_i) begin
        fill_cnt_q <= '0;
      end else if (accept_c) begin
        for (int unsigned i = 0; i < OUT_SIZE; i++) begin
          if (fill_cnt_q == CNT_W'(i))
            shadow_q[i] <= wr_data_i;
        end
        fill_cnt_q <= fill_cnt_q + CNT_W'(1);
      end
    end
  end

  // Outputs come straight from registers
  always_comb begin
    offset_o       = active_q;
    offset_valid_o = valid_q;
    fill_cnt_o     = fill_cnt_q;
    full_o         = (state_q == LD_FULL);
  end

endmodule

// File: tb/tb_offset_loader.sv
// Randomized bench for offset_loader against a queue-based reference model.
module tb_offset_loader;
  import offset_loader_pkg::*;

  localparam int unsigned N  = OFFSET_SIZE;
  localparam int unsigned CW = $clog2(N+1);

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic                wr_valid_i = 1'b0;
  data_type            wr_data_i = '0;
  logic                wr_ready_o;
  logic                abort_i = 1'b0;
  logic                apply_i = 1'b0;
  data_type [0:N-1]    offset_o;
  logic                offset_valid_o;
  logic [CW-1:0]       fill_cnt_o;
  logic                full_o;

  offset_loader #(.OUT_SIZE(N)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .wr_valid_i     (wr_valid_i),
    .wr_data_i      (wr_data_i),
    .wr_ready_o     (wr_ready_o),
    .abort_i        (abort_i),
    .apply_i        (apply_i),
    .offset_o       (offset_o),
    .offset_valid_o (offset_valid_o),
    .fill_cnt_o     (fill_cnt_o),
    .full_o         (full_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: pending words in a queue, committed set in an array
  data_type sh_m[$];
  data_type act_m [N];
  bit       valid_m;
  bit       rdy_m;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_ready(input bit ab);
    return rdy_m && (sh_m.size() < N) && !ab;
  endfunction

  task automatic model_reset();
    sh_m.delete();
    foreach (act_m[i]) act_m[i] = '0;
    valid_m = 1'b0;
    rdy_m   = 1'b0;
  endtask

  task automatic check_outs(input string tag);
    for (int i = 0; i < int'(N); i++)
      chk($sformatf("%s.offset[%0d]", tag, i), 32'(offset_o[i]), 32'(act_m[i]));
    chk({tag, ".valid"}, 32'(offset_valid_o), 32'(valid_m));
    chk({tag, ".fill_cnt"}, 32'(fill_cnt_o), 32'(sh_m.size()));
    chk({tag, ".full"}, 32'(full_o), 32'(sh_m.size() == N));
  endtask

  // One clock cycle: drive, check ready, clock, update model, check registered outputs
  task automatic step(input string tag, input bit v, input data_type d, input bit ab, input bit ap);
    bit acc;
    bit full;
    @(negedge clk_i);
    wr_valid_i = v;
    wr_data_i  = d;
    abort_i    = ab;
    apply_i    = ap;
    #1;
    chk({tag, ".ready"}, 32'(wr_ready_o), 32'(exp_ready(ab)));
    acc  = v && exp_ready(ab);
    full = (sh_m.size() == N);
    @(posedge clk_i);
    #1;
    if (full && ap) begin
      for (int i = 0; i < int'(N); i++) act_m[i] = sh_m[i];
      valid_m = 1'b1;
      sh_m.delete();
    end else if (ab) begin
      sh_m.delete();
    end else if (acc) begin
      sh_m.push_back(d);
    end
    rdy_m = 1'b1;
    check_outs(tag);
  endtask

  // Asynchronous reset mid-cycle, checked immediately, then released
  task automatic do_reset(input string tag, input int cycles);
    @(negedge clk_i);
    #2;
    rst_ni     = 1'b0;
    wr_valid_i = 1'b0;
    wr_data_i  = '0;
    abort_i    = 1'b0;
    apply_i    = 1'b0;
    #1;
    model_reset();
    check_outs({tag, ".async"});
    chk({tag, ".ready_in_rst"}, 32'(wr_ready_o), 32'(0));
    repeat (cycles) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk({tag, ".ready_at_release"}, 32'(wr_ready_o), 32'(0));
    @(posedge clk_i);
    #1;
    rdy_m = 1'b1;
    chk({tag, ".ready_after_edge"}, 32'(wr_ready_o), 32'(1));
    check_outs({tag, ".post"});
  endtask

  function automatic data_type rnd_word();
    return data_type'($urandom);
  endfunction

  initial begin
    int guard;
    model_reset();

    // Reset held for 10 cycles, then released
    do_reset("rst", 10);

    // Ramp set 3*i+1, one extra word while full, then apply
    for (int i = 0; i < int'(N); i++) step("ramp", 1'b1, data_type'(3*i+1), 1'b0, 1'b0);
    step("ramp_extra", 1'b1, data_type'(16'h7777), 1'b0, 1'b0);
    step("ramp_apply", 1'b0, '0, 1'b0, 1'b1);

    // Backpressure: toggling valid, random data
    for (int c = 0; c < 40; c++) step("bp", 1'($urandom), rnd_word(), 1'b0, 1'b0);
    guard = 0;
    while (sh_m.size() < N && guard < 2*int'(N)) begin
      step("bp_top", 1'b1, rnd_word(), 1'b0, 1'b0);
      guard++;
    end
    chk("bp_filled", 32'(sh_m.size()), 32'(N));
    step("bp_apply", 1'b1, rnd_word(), 1'b0, 1'b1);

    // Abort after 5 words, then reload 100+i
    for (int i = 0; i < 5; i++) step("ab_part", 1'b1, rnd_word(), 1'b0, 1'b0);
    step("ab_abort", 1'b1, rnd_word(), 1'b1, 1'b0);
    for (int i = 0; i < int'(N); i++) step("ab_load", 1'b1, data_type'(100+i), 1'b0, 1'b0);
    step("ab_apply", 1'b0, '0, 1'b0, 1'b1);

    // Apply ignored in FILL at count 7; apply & abort in FULL commits
    for (int i = 0; i < 7; i++) step("ap7", 1'b1, rnd_word(), 1'b0, 1'b0);
    step("ap7_ignored", 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < int'(N) - 7; i++) step("ap7_fill", 1'b1, rnd_word(), 1'b0, 1'b0);
    step("ap_ab_both", 1'b0, '0, 1'b1, 1'b1);

    // Abort alone in FULL drops the set, active unchanged
    for (int i = 0; i < int'(N); i++) step("fab", 1'b1, rnd_word(), 1'b0, 1'b0);
    step("fab_abort", 1'b0, '0, 1'b1, 1'b0);
    step("fab_apply_late", 1'b0, '0, 1'b0, 1'b1);

    // Random full-range set (raw copy incl. negative values), then reset mid-load
    for (int i = 0; i < int'(N); i++) step("rnd", 1'b1, rnd_word(), 1'b0, 1'b0);
    step("rnd_apply", 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step("mid", 1'b1, rnd_word(), 1'b0, 1'b0);
    do_reset("mid_rst", 3);

    // Random soak with occasional abort and apply
    for (int c = 0; c < 400; c++)
      step("soak", ($urandom_range(0, 3) != 0), rnd_word(),
           ($urandom_range(0, 31) == 0), ($urandom_range(0, 5) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
